// File: rtl/rv32e_mem_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | rv32e_mem_arbiter_pkg : shared types for the fetch/data memory arbiter   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv32e_mem_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GNT_IF = 4'b0010,
    ST_GNT_D  = 4'b0100,
    ST_RESP   = 4'b1000
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  // A tie goes to data unless round-robin is on and data won the previous grant.
  function automatic grant_e pick_grant(input logic   if_req,
                                        input logic   d_req,
                                        input logic   rr_en,
                                        input grant_e last);
    if (if_req && d_req) return (rr_en && last == GNT_D) ? GNT_IF : GNT_D;
    else if (d_req)      return GNT_D;
    else                 return GNT_IF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32e_mem_arbiter_timeout.sv
// +--------------------------------------------------------------------------+
// | rv32e_mem_arbiter_timeout : counts un-acked grant cycles, flags expiry   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv32e_mem_arbiter_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] c_last_cnt = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the TIMEOUT-th waiting cycle, so the grant lasts exactly TIMEOUT cycles.
  assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q == c_last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                      cnt_d = '0;
    else if (enable_i && !expired_o)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/rv32e_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | rv32e_mem_arbiter : shares one memory port between fetch and data ports  |
// | Option macro: ARB_ROUND_ROBIN_EN (alternate on ties). Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv32e_mem_arbiter
  import rv32e_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ready_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic [3:0]    d_wstrb_i,
  output logic          d_ready_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          bus_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_wstrb_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic c_rr_en = 1'b1;
`else
  localparam logic c_rr_en = 1'b0;
`endif

  state_e        state_q, state_d;
  grant_e        gnt_q, gnt_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          in_gnt;
  logic          expired;

  assign in_gnt = (state_q == ST_GNT_IF) || (state_q == ST_GNT_D);

  rv32e_mem_arbiter_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!in_gnt),
    .enable_i  (in_gnt && !mem_ack_i),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        bus_err_d = 1'b0;
        if (if_req_i || d_req_i) begin
          // gnt_q doubles as the last-grant flop for round-robin ties.
          gnt_d = pick_grant(if_req_i, d_req_i, c_rr_en, gnt_q);
          if (gnt_d == GNT_D) begin
            state_d     = ST_GNT_D;
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            mem_wstrb_d = d_we_i ? d_wstrb_i : WSTRB_NONE;
          end else begin
            state_d     = ST_GNT_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wstrb_d = WSTRB_NONE;
          end
        end
      end
      ST_GNT_IF, ST_GNT_D: begin
        if (mem_ack_i) begin
          state_d = ST_RESP;
          if (state_q == ST_GNT_D) d_rdata_d  = mem_rdata_i;
          else                     if_rdata_d = mem_rdata_i;
        end else if (expired) begin
          state_d   = ST_RESP;
          bus_err_d = 1'b1;
          if (state_q == ST_GNT_D) d_rdata_d  = '0;
          else                     if_rdata_d = '0;
        end
      end
      ST_RESP: begin
        state_d   = ST_IDLE;
        bus_err_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= WSTRB_NONE;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req_o   = in_gnt;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign if_ready_o  = (state_q == ST_RESP) && (gnt_q == GNT_IF);
  assign d_ready_o   = (state_q == ST_RESP) && (gnt_q == GNT_D);
  assign bus_err_o   = bus_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32e_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_rv32e_mem_arbiter : randomized transaction-level check of the arbiter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rv32e_mem_arbiter;

  localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic        if_ready, d_ready, bus_err, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  rv32e_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_ready_o (if_ready),
    .if_rdata_o (if_rdata),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_wstrb_i  (d_wstrb),
    .d_ready_o  (d_ready),
    .d_rdata_o  (d_rdata),
    .bus_err_o  (bus_err),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pending requests per port and the model's view of the result registers.
  bit          if_pend, d_pend, p_dw;
  logic [31:0] p_ia, p_da, p_dwd;
  logic [3:0]  p_ds;
  bit          last_d;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if_req  = if_pend;
    if_addr = p_ia;
    d_req   = d_pend;
    d_we    = p_dw;
    d_addr  = p_da;
    d_wdata = p_dwd;
    d_wstrb = p_ds;
  endtask

  task automatic new_if(input logic [31:0] a);
    if_pend = 1'b1;
    p_ia    = a;
  endtask

  task automatic new_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    d_pend = 1'b1;
    p_dw   = we;
    p_da   = a;
    p_dwd  = wd;
    p_ds   = s;
  endtask

  task automatic refill(input bit both);
    logic [31:0] a;
    if (!if_pend && (both || $urandom_range(0, 9) < 6)) begin
      a = $urandom; a[1:0] = 2'b00;
      new_if(a);
    end
    if (!d_pend && (both || !if_pend || $urandom_range(0, 9) < 6)) begin
      a = $urandom; a[1:0] = 2'b00;
      new_d($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(1, 15)));
    end
    drive();
  endtask

  // Entered on a falling edge with the DUT idle and requests driven; returns on
  // the falling edge after the ready pulse, again idle.
  task automatic do_txn(input int dly, input logic [31:0] rd);
    bit          win_d, tmo;
    int          len;
    logic [31:0] v;
    chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
    win_d  = (if_pend && d_pend) ? (RR ? !last_d : 1'b1) : d_pend;
    last_d = win_d;
    tmo    = (dly >= TO);
    len    = tmo ? TO : dly + 1;
    @(negedge clk);
    chk("grant_mem_req", {31'b0, mem_req}, 32'd1);
    if (win_d) begin
      chk("d_mem_addr", mem_addr, p_da);
      chk("d_mem_we", {31'b0, mem_we}, {31'b0, p_dw});
      chk("d_mem_wstrb", {28'b0, mem_wstrb}, p_dw ? {28'b0, p_ds} : 32'd0);
      if (p_dw) chk("d_mem_wdata", mem_wdata, p_dwd);
    end else begin
      chk("if_mem_addr", mem_addr, p_ia);
      chk("if_mem_we", {31'b0, mem_we}, 32'd0);
      chk("if_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    end
    // Requester may withdraw once granted; the transaction must still finish.
    if ($urandom_range(0, 3) == 0) begin
      if (win_d) d_req = 1'b0;
      else       if_req = 1'b0;
    end
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("hold_mem_req", {31'b0, mem_req}, 32'd1);
        chk("hold_mem_addr", mem_addr, win_d ? p_da : p_ia);
      end
      mem_ack   = (k == dly);
      mem_rdata = (k == dly) ? rd : $urandom;
    end
    @(negedge clk);
    mem_ack   = $urandom_range(0, 1) == 1;
    mem_rdata = $urandom;
    v = tmo ? 32'd0 : rd;
    if (win_d) exp_d_rdata  = v;
    else       exp_if_rdata = v;
    chk("resp_mem_req", {31'b0, mem_req}, 32'd0);
    chk("resp_if_ready", {31'b0, if_ready}, {31'b0, !win_d});
    chk("resp_d_ready", {31'b0, d_ready}, {31'b0, win_d});
    chk("resp_bus_err", {31'b0, bus_err}, {31'b0, tmo});
    if (win_d) chk("resp_d_rdata", d_rdata, exp_d_rdata);
    else       chk("resp_if_rdata", if_rdata, exp_if_rdata);
    if (win_d) d_pend = 1'b0;
    else       if_pend = 1'b0;
    drive();
    @(negedge clk);
    mem_ack = 1'b0;
    chk("post_if_ready", {31'b0, if_ready}, 32'd0);
    chk("post_d_ready", {31'b0, d_ready}, 32'd0);
    chk("post_bus_err", {31'b0, bus_err}, 32'd0);
    chk("post_mem_req", {31'b0, mem_req}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
    chk({tag, "_readys"}, {30'b0, if_ready, d_ready}, 32'd0);
    chk({tag, "_bus_err"}, {31'b0, bus_err}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    if_pend = 1'b0; d_pend = 1'b0; p_dw = 1'b0;
    p_ia = '0; p_da = '0; p_dwd = '0; p_ds = '0;
    last_d = 1'b0; exp_if_rdata = '0; exp_d_rdata = '0;
    drive();
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);

    // Fetch of 0x10 acked on the third grant cycle.
    new_if(32'h10); drive();
    do_txn(2, 32'h0050_0093);
    chk("fetch_if_rdata", if_rdata, 32'h0050_0093);

    // Full-word store.
    new_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111); drive();
    do_txn(1, $urandom);

    // Both ports held with immediate ack.
    for (int i = 0; i < 6; i++) begin
      refill(1'b1);
      do_txn(0, $urandom);
    end
    if_pend = 1'b0; d_pend = 1'b0; drive();
    @(negedge clk);

    // Load that never acks, followed by a normal one; then ack on the expiry cycle.
    new_d(1'b0, 32'h200, 32'h0, 4'b0000); drive();
    do_txn(TO + 1, $urandom);
    new_d(1'b0, 32'h204, 32'h0, 4'b0000); drive();
    do_txn(1, 32'h1234_5678);
    new_if(32'h300); drive();
    do_txn(TO - 1, 32'hCAFE_F00D);

    for (int i = 0; i < 250; i++) begin
      refill(1'b0);
      do_txn($urandom_range(0, TO + 1), $urandom);
    end

    // Reset while a fetch is granted, then a late ack.
    if_pend = 1'b0; d_pend = 1'b0; drive();
    @(negedge clk);
    new_if(32'h40); drive();
    @(negedge clk);
    chk("pre_reset_mem_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b0;
    if_pend = 1'b0; drive();
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    chk_reset_state("midrst");
    @(negedge clk);
    mem_ack = 1'b0;
    chk_reset_state("late_ack");
    last_d = 1'b0; exp_if_rdata = '0; exp_d_rdata = '0;

    // First tie after reset goes to data in both builds.
    refill(1'b1);
    do_txn(0, $urandom);
    chk("after_reset_if_rdata", if_rdata, exp_if_rdata);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
